// File: rtl/csr_trap_sequencer_pkg.sv
// Shared constants for the CSR port sequencer: FSM states, CSR numbers and
// the CSR file access-type codes.
package csr_trap_sequencer_pkg;

   typedef logic [2:0] seq_state_t;
   typedef logic [1:0] csr_access_t;

   localparam seq_state_t ST_IDLE       = 3'd0;
   localparam seq_state_t ST_TRAP_EPC   = 3'd1;
   localparam seq_state_t ST_TRAP_CAUSE = 3'd2;
   localparam seq_state_t ST_TRAP_VEC   = 3'd3;
   localparam seq_state_t ST_MRET_EPC   = 3'd4;

   localparam csr_access_t CSR_READ_ONLY = 2'b00;
   localparam csr_access_t CSR_WRITE     = 2'b01;
   localparam csr_access_t CSR_SET       = 2'b10;
   localparam csr_access_t CSR_CLEAR     = 2'b11;

   localparam logic [11:0] CSR_NUM_MEPC   = 12'h341;
   localparam logic [11:0] CSR_NUM_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_NUM_MTVEC  = 12'h305;

   // mtvec direct mode: the low two bits are the mode field, not address bits
   function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
      return mtvec & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Request, trap/mret, redirect and CSR-file port bundle around the sequencer.
interface csr_trap_sequencer_if;
   import csr_trap_sequencer_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic [11:0] req_number;
   csr_access_t req_type;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        mret_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic [11:0] csr_number;
   csr_access_t csr_access_type;
   logic [31:0] csr_in;
   logic [31:0] csr_out;

   // master: pipeline plus CSR file side; slave: the sequencer
   modport master (
      output req_valid, req_number, req_type, req_wdata,
      output trap_valid, trap_pc, trap_cause, mret_valid, csr_out,
      input  req_ready, resp_valid, resp_rdata, redirect_valid, redirect_pc,
      input  busy, csr_number, csr_access_type, csr_in
   );

   modport slave (
      input  req_valid, req_number, req_type, req_wdata,
      input  trap_valid, trap_pc, trap_cause, mret_valid, csr_out,
      output req_ready, resp_valid, resp_rdata, redirect_valid, redirect_pc,
      output busy, csr_number, csr_access_type, csr_in
   );

endinterface

// File: rtl/csr_trap_sequencer.sv
// Arbitrates the single CSR file port between instruction CSR accesses,
// trap entry (write mepc, write mcause, read mtvec) and mret (read mepc).
module csr_trap_sequencer
   import csr_trap_sequencer_pkg::*;
#(
   parameter logic [11:0] MEPC_ADDR   = CSR_NUM_MEPC,
   parameter logic [11:0] MCAUSE_ADDR = CSR_NUM_MCAUSE,
   parameter logic [11:0] MTVEC_ADDR  = CSR_NUM_MTVEC
) (
   input  logic                 clk,
   input  logic                 rst,
   csr_trap_sequencer_if.slave  bus
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q, cause_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        accept_req, accept_trap, req_ready;
   logic [11:0] csr_number;
   csr_access_t csr_access_type;
   logic [31:0] csr_in;

   always_comb begin
      state_d          = state_q;
      csr_number       = '0;
      csr_access_type  = CSR_READ_ONLY;
      csr_in           = '0;
      req_ready        = 1'b0;
      accept_req       = 1'b0;
      accept_trap      = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.trap_valid) begin
               accept_trap = 1'b1;
               state_d     = ST_TRAP_EPC;
            end else if (bus.mret_valid) begin
               state_d = ST_MRET_EPC;
            end else begin
               req_ready = 1'b1;
               if (bus.req_valid) begin
                  accept_req      = 1'b1;
                  csr_number      = bus.req_number;
                  csr_access_type = bus.req_type;
                  csr_in          = bus.req_wdata;
               end
            end
         end
         ST_TRAP_EPC: begin
            csr_number      = MEPC_ADDR;
            csr_access_type = CSR_WRITE;
            csr_in          = pc_q;
            state_d         = ST_TRAP_CAUSE;
         end
         ST_TRAP_CAUSE: begin
            csr_number      = MCAUSE_ADDR;
            csr_access_type = CSR_WRITE;
            csr_in          = cause_q;
            state_d         = ST_TRAP_VEC;
         end
         ST_TRAP_VEC: begin
            csr_number       = MTVEC_ADDR;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mtvec_base(bus.csr_out);
            state_d          = ST_IDLE;
         end
         ST_MRET_EPC: begin
            csr_number       = MEPC_ADDR;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.csr_out;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         pc_q             <= '0;
         cause_q          <= '0;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         resp_valid_q     <= accept_req;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         // pre-access value: the CSR file updates on this same edge
         if (accept_req) resp_rdata_q <= bus.csr_out;
         if (accept_trap) begin
            pc_q    <= bus.trap_pc;
            cause_q <= bus.trap_cause;
         end
      end
   end

   assign bus.req_ready       = req_ready;
   assign bus.resp_valid      = resp_valid_q;
   assign bus.resp_rdata      = resp_rdata_q;
   assign bus.redirect_valid  = redirect_valid_q;
   assign bus.redirect_pc     = redirect_pc_q;
   assign bus.busy            = (state_q != ST_IDLE);
   assign bus.csr_number      = csr_number;
   assign bus.csr_access_type = csr_access_type;
   assign bus.csr_in          = csr_in;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench: table of CSR accesses against a behavioural CSR file,
// plus hand-written trap, mret, priority and mid-sequence reset sequences.
module tb_csr_trap_sequencer;
   import csr_trap_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;
   int   wr_before;

   csr_trap_sequencer_if bus ();

   csr_trap_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // behavioural CSR file: combinational read, write/set/clear on the edge
   logic [31:0] mem [0:4095] = '{default: 32'h0};
   assign bus.csr_out = mem[bus.csr_number];

   always @(posedge clk) begin
      case (bus.csr_access_type)
         CSR_WRITE: begin mem[bus.csr_number] <= bus.csr_in;                        wr_cnt <= wr_cnt + 1; end
         CSR_SET:   begin mem[bus.csr_number] <= mem[bus.csr_number] | bus.csr_in;  wr_cnt <= wr_cnt + 1; end
         CSR_CLEAR: begin mem[bus.csr_number] <= mem[bus.csr_number] & ~bus.csr_in; wr_cnt <= wr_cnt + 1; end
         default: ;
      endcase
   end

   typedef struct {
      logic [11:0] num;
      logic [1:0]  typ;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] after;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // one-cycle request; checks ready, one-cycle response latency and CSR effect
   task automatic do_req(input string nm, input logic [11:0] num, input logic [1:0] typ,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [31:0] after);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_number = num;
      bus.req_type   = typ;
      bus.req_wdata  = wdata;
      #1 chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk({nm, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({nm, " resp_rdata"}, bus.resp_rdata, rdata);
      chk({nm, " csr after"}, mem[num], after);
      @(negedge clk);
      chk({nm, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
      chk({nm, " resp_rdata hold"}, bus.resp_rdata, rdata);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_number = '0;
      bus.req_type   = CSR_READ_ONLY;
      bus.req_wdata  = '0;
      bus.trap_valid = 1'b0;
      bus.trap_pc    = '0;
      bus.trap_cause = '0;
      bus.mret_valid = 1'b0;

      vecs[0] = '{12'h341, CSR_WRITE,     32'h0000_0100, 32'h0000_0000, 32'h0000_0100};
      vecs[1] = '{12'h341, CSR_SET,       32'h0000_00F0, 32'h0000_0100, 32'h0000_01F0};
      vecs[2] = '{12'h341, CSR_CLEAR,     32'h0000_0010, 32'h0000_01F0, 32'h0000_01E0};
      vecs[3] = '{12'h341, CSR_READ_ONLY, 32'h0000_FFFF, 32'h0000_01E0, 32'h0000_01E0};
      vecs[4] = '{12'h305, CSR_WRITE,     32'h0000_8003, 32'h0000_0000, 32'h0000_8003};
      vecs[5] = '{12'h342, CSR_WRITE,     32'h0000_DEAD, 32'h0000_0000, 32'h0000_DEAD};
      vecs[6] = '{12'h342, CSR_READ_ONLY, 32'h0000_0000, 32'h0000_DEAD, 32'h0000_DEAD};

      // reset state
      #12;
      chk("rst busy",        32'(bus.busy), 32'd0);
      chk("rst resp_valid",  32'(bus.resp_valid), 32'd0);
      chk("rst resp_rdata",  bus.resp_rdata, 32'd0);
      chk("rst redir_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst redir_pc",    bus.redirect_pc, 32'd0);
      chk("rst csr_number",  32'(bus.csr_number), 32'd0);
      chk("rst csr_type",    32'(bus.csr_access_type), 32'(CSR_READ_ONLY));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         do_req($sformatf("vec%0d", i), vecs[i].num, vecs[i].typ, vecs[i].wdata,
                vecs[i].rdata, vecs[i].after);

      // trap entry: mtvec=0x8003 -> redirect 0x8000 at N+4
      @(negedge clk);
      bus.trap_valid = 1'b1;
      bus.trap_pc    = 32'h2000;
      bus.trap_cause = 32'h2;
      #1 chk("trap req_ready", 32'(bus.req_ready), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         bus.trap_valid = 1'b0;
         chk($sformatf("trap busy N+%0d", k), 32'(bus.busy), (k <= 3) ? 32'd1 : 32'd0);
         chk($sformatf("trap redir N+%0d", k), 32'(bus.redirect_valid), (k == 4) ? 32'd1 : 32'd0);
         if (k == 2) chk("trap mepc", mem[12'h341], 32'h2000);
         if (k == 3) chk("trap mcause", mem[12'h342], 32'h2);
         if (k >= 4) chk($sformatf("trap redir_pc N+%0d", k), bus.redirect_pc, 32'h8000);
      end

      // mret: mepc=0x2004 -> redirect at N+2 with no CSR writes
      do_req("set mepc", 12'h341, CSR_WRITE, 32'h2004, 32'h2000, 32'h2004);
      wr_before = wr_cnt;
      @(negedge clk);
      bus.mret_valid = 1'b1;
      #1 chk("mret req_ready", 32'(bus.req_ready), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         bus.mret_valid = 1'b0;
         chk($sformatf("mret busy N+%0d", k), 32'(bus.busy), (k == 1) ? 32'd1 : 32'd0);
         chk($sformatf("mret redir N+%0d", k), 32'(bus.redirect_valid), (k == 2) ? 32'd1 : 32'd0);
      end
      chk("mret redir_pc", bus.redirect_pc, 32'h2004);
      chk("mret no writes", 32'(wr_cnt), 32'(wr_before));

      // all three at once: trap wins, mret during busy dropped, held req served at N+4
      @(negedge clk);
      bus.trap_valid = 1'b1;
      bus.trap_pc    = 32'h3000;
      bus.trap_cause = 32'h7;
      bus.mret_valid = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_number = 12'h342;
      bus.req_type   = CSR_READ_ONLY;
      bus.req_wdata  = '0;
      #1 chk("prio req_ready", 32'(bus.req_ready), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         bus.trap_valid = 1'b0;
         bus.mret_valid = (k == 2);
         if (k == 5) bus.req_valid = 1'b0;
         #1;
         chk($sformatf("prio ready N+%0d", k), 32'(bus.req_ready), (k == 4) ? 32'd1 : ((k >= 5) ? 32'd1 : 32'd0));
         chk($sformatf("prio resp N+%0d", k), 32'(bus.resp_valid), (k == 5) ? 32'd1 : 32'd0);
         chk($sformatf("prio redir N+%0d", k), 32'(bus.redirect_valid), (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("prio busy N+%0d", k), 32'(bus.busy), (k <= 3) ? 32'd1 : 32'd0);
      end
      chk("prio resp_rdata", bus.resp_rdata, 32'h7);
      chk("prio mepc", mem[12'h341], 32'h3000);

      // reset during TRAP_CAUSE: abort, mepc already written, mcause untouched
      @(negedge clk);
      bus.trap_valid = 1'b1;
      bus.trap_pc    = 32'h4000;
      bus.trap_cause = 32'hB;
      @(negedge clk);
      bus.trap_valid = 1'b0;
      @(negedge clk);
      chk("rstmid busy before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid busy", 32'(bus.busy), 32'd0);
      chk("rstmid redir_pc", bus.redirect_pc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rstmid redir %0d", k), 32'(bus.redirect_valid), 32'd0);
         chk($sformatf("rstmid busy %0d", k), 32'(bus.busy), 32'd0);
      end
      chk("rstmid mepc", mem[12'h341], 32'h4000);
      chk("rstmid mcause", mem[12'h342], 32'h7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Owns the single CSR register-file port and shares it between three requesters: instruction CSR accesses (CSRRW/CSRRS/CSRRC), trap entry, and mret.
- Trap entry is sequenced as a multi-cycle write of mepc, then mcause, then a read of mtvec to redirect fetch.
- mret reads mepc and redirects fetch to it.
- Sits between decode/execute and the CSR register file; issues CSR number, access type and write data, and consumes CSR read data.

Parameters:
- MEPC_ADDR, 12'h341, CSR number of mepc
- MCAUSE_ADDR, 12'h342, CSR number of mcause
- MTVEC_ADDR, 12'h305, CSR number of mtvec

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  instruction CSR access request
- req_ready  out  1  request accepted this cycle
- req_number  in  12  CSR number
- req_type  in  2  access type (CSR header codes)
- req_wdata  in  32  operand for write/set/clear
- resp_valid  out  1  read data valid (one-cycle pulse)
- resp_rdata  out  32  CSR value before the access
- trap_valid  in  1  trap entry request
- trap_pc  in  32  pc of faulting instruction
- trap_cause  in  32  mcause value
- mret_valid  in  1  mret request
- redirect_valid  out  1  fetch redirect (one-cycle pulse)
- redirect_pc  out  32  redirect target
- busy  out  1  sequence in progress
- csr_number  out  12  to CSR file
- csr_access_type  out  2  to CSR file
- csr_in  out  32  to CSR file
- csr_out  in  32  from CSR file (combinational read)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; resp_valid, redirect_valid and busy are 0; resp_rdata, redirect_pc and the latched pc/cause are 0.
- States: IDLE, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_EPC.
- Default CSR port drive (IDLE with nothing accepted, or any state not listed below): csr_number=0, csr_access_type=CSR_READ_ONLY, csr_in=0. The port never writes when idle.
- IDLE arbitration, fixed priority trap_valid > mret_valid > req_valid:
  - trap_valid: latch trap_pc and trap_cause; next state TRAP_EPC.
  - else mret_valid: next state MRET_EPC.
  - else req_valid: drive csr_number=req_number, csr_access_type=req_type, csr_in=req_wdata combinationally in the same cycle. Register csr_out into resp_rdata and pulse resp_valid in the next cycle (latency 1). The returned data is the pre-write value. Stay in IDLE.
- req_ready = (state==IDLE) && !trap_valid && !mret_valid. A request that is not accepted must be held by the requester.
- TRAP_EPC: drive MEPC_ADDR, CSR_WRITE, latched pc; next state TRAP_CAUSE.
- TRAP_CAUSE: drive MCAUSE_ADDR, CSR_WRITE, latched cause; next state TRAP_VEC.
- TRAP_VEC: drive MTVEC_ADDR, CSR_READ_ONLY; register redirect_pc = csr_out & ~32'h3 (direct mode); next state IDLE. redirect_valid is high for exactly the following cycle.
- MRET_EPC: drive MEPC_ADDR, CSR_READ_ONLY; register redirect_pc = csr_out; next state IDLE. redirect_valid pulses in the following cycle.
- Latency: trap accepted in cycle N gives redirect_valid in N+4. mret accepted in cycle N gives redirect_valid in N+2.
- busy = (state != IDLE).
- trap_valid, mret_valid and req_valid are ignored while busy and are not queued; the upstream holds or retries them.
- A new request may be accepted in the same cycle that redirect_valid pulses.
- Reset mid-sequence: return immediately to IDLE, no redirect pulse. CSR writes already completed (e.g. mepc) are not undone.
- redirect_pc holds its last value when redirect_valid is low. resp_rdata holds when resp_valid is low.

Decomposition:
- Shared package: state enum, CSR address constants (mepc/mcause/mtvec), the existing CSR access-type codes (READ_ONLY, WRITE, SET, CLEAR).
- No sub-module needed. One always_ff for state, latches and outputs; one always_comb for next-state and CSR port muxing.

Test Plan:
- req_valid, number 0x341, CSR_WRITE, wdata 0x100 with mepc=0 -> req_ready=1; next cycle resp_valid=1, resp_rdata=0; mepc then reads 0x100.
- mepc=0x100, CSR_SET with wdata 0x0F0 -> resp_rdata=0x100, mepc becomes 0x1F0. Then CSR_CLEAR with 0x010 -> mepc 0x1E0.
- trap_valid in cycle N, pc 0x2000, cause 0x2, CSR-model mtvec 0x8003 -> busy in N+1..N+3; mepc=0x2000, mcause=2; redirect_valid only in N+4 with redirect_pc 0x8000.
- mepc=0x2004, mret_valid in cycle N -> redirect_valid in N+2, redirect_pc 0x2004. No CSR write occurs during the sequence.
- trap_valid, mret_valid and req_valid all high in the same IDLE cycle -> trap sequence runs; req_ready=0 until IDLE; req is served afterwards; mret during busy is dropped.
- rst asserted during TRAP_CAUSE -> asynchronous return to IDLE, busy=0, no redirect_valid; mepc keeps the trap pc and mcause is unchanged.
